reg_bank_writeback: RTL and testbench

//  Write side of the 8-entry register bank. Accepts write-back requests (reg number + data).

---
 rtl/reg_bank_writeback.sv | 84 ++++++++
 tb/tb_reg_bank_writeback.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_bank_writeback.sv
// reg_bank_writeback: in-order write-back queue committing one entry per cycle into r0..r7
module reg_bank_writeback #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wb_valid,
   output logic             wb_ready,
   input  logic [2:0]       wb_reg,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             hold,
   output logic [7:0]       pending,
   output logic [CW-1:0]    q_count,
   output logic [WIDTH-1:0] r0,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] r4,
   output logic [WIDTH-1:0] r5,
   output logic [WIDTH-1:0] r6,
   output logic [WIDTH-1:0] r7
);
   logic [WIDTH-1:0] rf [8];
   logic [2:0]       q_reg [DEPTH];
   logic [WIDTH-1:0] q_dat [DEPTH];
   logic [DEPTH-1:0] vld, vld_n;
   logic [PW-1:0]    head, tail;
   logic             push, pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign wb_ready = !reset && (q_count < CW'(DEPTH));
   assign push = wb_valid && wb_ready;
   assign pop = !hold && (q_count != '0);

   // head and tail never coincide when both push and pop fire, so slot updates are disjoint
   always_comb begin
      vld_n = vld;
      if (pop) vld_n[head] = 1'b0;
      if (push) vld_n[tail] = 1'b1;
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i]) pending[q_reg[i]] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         q_count <= '0;
         vld <= '0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         if (push) begin
            q_reg[tail] <= wb_reg;
            q_dat[tail] <= wb_data;
            tail <= inc(tail);
         end
         if (pop) begin
            rf[q_reg[head]] <= q_dat[head];
            head <= inc(head);
         end
         q_count <= q_count + CW'(push) - CW'(pop);
         vld <= vld_n;
      end
   end

   assign r0 = rf[0];
   assign r1 = rf[1];
   assign r2 = rf[2];
   assign r3 = rf[3];
   assign r4 = rf[4];
   assign r5 = rf[5];
   assign r6 = rf[6];
   assign r7 = rf[7];
endmodule

// File: tb/tb_reg_bank_writeback.sv
// tb_reg_bank_writeback: directed checks of queueing, commit order, hold and reset
module tb_reg_bank_writeback;
   logic        clock = 1'b0;
   logic        reset, wb_valid, wb_ready, hold;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;
   logic [7:0]  pending;
   logic [1:0]  q_count;
   logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
   int          vectors = 0;
   int          miscompares = 0;

   reg_bank_writeback #(.WIDTH(16), .DEPTH(2)) dut (
      .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_reg(wb_reg), .wb_data(wb_data), .hold(hold), .pending(pending),
      .q_count(q_count), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
      .r6(r6), .r7(r7)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic v, input logic [2:0] r, input logic [15:0] d);
      wb_valid = v;
      wb_reg = r;
      wb_data = d;
   endtask

   initial begin
      reset = 1'b1;
      hold = 1'b0;
      put(1'b1, 3'd3, 16'hBEEF);
      #1;
      chk("rst_ready0", wb_ready, 0);
      step();
      chk("rst_ready1", wb_ready, 0);
      chk("rst_q1", q_count, 0);
      step();
      chk("rst_regs", {r0, r1, r2, r3, r4, r5, r6, r7}, 0);
      chk("rst_q2", q_count, 0);
      chk("rst_pend", pending, 0);
      chk("rst_ready2", wb_ready, 0);
      reset = 1'b0;
      put(1'b0, 3'd0, 16'h0);
      #1;
      chk("rel_ready", wb_ready, 1);
      step();
      chk("rel_r3", r3, 0);
      chk("rel_q", q_count, 0);

      put(1'b1, 3'd5, 16'h1234);
      step();
      put(1'b0, 3'd0, 16'h0);
      chk("sw_pend", pending, 8'b0010_0000);
      chk("sw_q", q_count, 1);
      chk("sw_r5_early", r5, 0);
      step();
      chk("sw_r5", r5, 16'h1234);
      chk("sw_pend0", pending, 0);
      chk("sw_q0", q_count, 0);

      hold = 1'b1;
      put(1'b1, 3'd1, 16'h0001);
      step();
      put(1'b1, 3'd2, 16'h0002);
      chk("fill_ready1", wb_ready, 1);
      step();
      put(1'b1, 3'd3, 16'h0003);
      chk("fill_ready0", wb_ready, 0);
      chk("fill_q2", q_count, 2);
      chk("fill_pend", pending, 8'b0000_0110);
      step();
      chk("fill_held_q", q_count, 2);
      chk("fill_held_r1", r1, 0);
      hold = 1'b0;
      step();
      chk("fill_r1", r1, 16'h0001);
      chk("fill_r2_wait", r2, 0);
      chk("fill_q1", q_count, 1);
      chk("fill_ready_back", wb_ready, 1);
      step();
      put(1'b0, 3'd0, 16'h0);
      chk("fill_r2", r2, 16'h0002);
      chk("fill_q_third", q_count, 1);
      chk("fill_pend3", pending, 8'b0000_1000);
      step();
      chk("fill_r3", r3, 16'h0003);
      chk("fill_qe", q_count, 0);

      put(1'b1, 3'd4, 16'hAAAA);
      step();
      put(1'b1, 3'd4, 16'h5555);
      step();
      put(1'b0, 3'd0, 16'h0);
      chk("ord_r4a", r4, 16'hAAAA);
      chk("ord_pend", pending, 8'b0001_0000);
      chk("ord_q", q_count, 1);
      step();
      chk("ord_r4b", r4, 16'h5555);
      chk("ord_pend0", pending, 0);

      put(1'b1, 3'd6, 16'h0066);
      step();
      put(1'b1, 3'd7, 16'h00FF);
      step();
      put(1'b0, 3'd0, 16'h0);
      chk("ac_q", q_count, 1);
      chk("ac_r6", r6, 16'h0066);
      chk("ac_r7_wait", r7, 0);
      chk("ac_pend", pending, 8'b1000_0000);
      step();
      chk("ac_r7", r7, 16'h00FF);
      chk("ac_q0", q_count, 0);

      hold = 1'b1;
      put(1'b1, 3'd2, 16'h2222);
      step();
      put(1'b1, 3'd3, 16'h3333);
      step();
      put(1'b0, 3'd0, 16'h0);
      chk("mid_q2", q_count, 2);
      chk("mid_pend", pending, 8'b0000_1100);
      reset = 1'b1;
      step();
      chk("mid_q0", q_count, 0);
      chk("mid_pend0", pending, 0);
      chk("mid_regs", {r0, r1, r2, r3, r4, r5, r6, r7}, 0);
      chk("mid_ready", wb_ready, 0);
      reset = 1'b0;
      hold = 1'b0;
      step();
      step();
      step();
      chk("post_regs", {r0, r1, r2, r3, r4, r5, r6, r7}, 0);
      chk("post_q", q_count, 0);
      chk("post_ready", wb_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
